// File: rtl/sprite_blitter.sv
// Sprite-to-framebuffer blitter: streams a sprite from a sync-read ROM into the framebuffer write port,
// clipping off-screen pixels. Optional colour-key skipping is enabled with `BLIT_TRANSPARENCY_EN.
module sprite_blitter #(
    parameter int DATA_WIDTH     = 13,
    parameter int FB_ADDR_WIDTH  = 15,
    parameter int FB_WIDTH       = 256,
    parameter int FB_HEIGHT      = 128,
    parameter int SPR_W          = 32,
    parameter int SPR_H          = 32,
    parameter int SPR_ADDR_WIDTH = 10,
    parameter logic [DATA_WIDTH-1:0] TRANSPARENT = 13'h0000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [$clog2(FB_WIDTH)-1:0]   x,
    input  logic [$clog2(FB_HEIGHT)-1:0]  y,
    output logic                          busy,
    output logic                          done,
    output logic [SPR_ADDR_WIDTH-1:0]     spr_addr,
    input  logic [DATA_WIDTH-1:0]         spr_data,
    output logic                          fb_we,
    output logic [FB_ADDR_WIDTH-1:0]      fb_addr,
    output logic [DATA_WIDTH-1:0]         fb_wdata
);

    localparam int XW = $clog2(FB_WIDTH);
    localparam int YW = $clog2(FB_HEIGHT);
    localparam int CW = $clog2(SPR_W);
    localparam int RW = SPR_ADDR_WIDTH - CW;
    localparam logic [SPR_ADDR_WIDTH-1:0] LAST_ADDR = SPR_ADDR_WIDTH'(SPR_W * SPR_H - 1);

    if (FB_WIDTH * FB_HEIGHT != 2 ** FB_ADDR_WIDTH || XW + YW != FB_ADDR_WIDTH) begin : g_bad_fb
        $error("sprite_blitter: framebuffer geometry does not match FB_ADDR_WIDTH");
    end
    if (SPR_W * SPR_H != 2 ** SPR_ADDR_WIDTH || $bits(TRANSPARENT) != DATA_WIDTH) begin : g_bad_spr
        $error("sprite_blitter: sprite geometry or colour key width mismatch");
    end

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t              state, state_n;
    logic                issue;
    logic [XW-1:0]       x_l;
    logic [YW-1:0]       y_l;
    logic                v1;
    logic [RW-1:0]       r1;
    logic [CW-1:0]       c1;
    logic [XW:0]         tx;
    logic [YW:0]         ty;
    logic                on_screen;
    logic                opaque;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state logic; DRAIN ends once the last pixel has left the address-align stage
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = FETCH;
            FETCH:   if (spr_addr == LAST_ADDR) state_n = DRAIN;
            DRAIN:   if (!v1) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy  = (state != IDLE);
        issue = (state == FETCH);
    end

    assign tx        = {1'b0, x_l} + (XW + 1)'(c1);
    assign ty        = {1'b0, y_l} + (YW + 1)'(r1);
    assign on_screen = (tx < (XW + 1)'(FB_WIDTH)) && (ty < (YW + 1)'(FB_HEIGHT));

`ifdef BLIT_TRANSPARENCY_EN
    assign opaque = (spr_data != TRANSPARENT);
`else
    assign opaque = 1'b1;
`endif

    // Address issue, row/column alignment stage, and registered write stage
    always_ff @(posedge clk) begin
        if (rst) begin
            spr_addr <= '0;
            x_l      <= '0;
            y_l      <= '0;
            v1       <= 1'b0;
            r1       <= '0;
            c1       <= '0;
            fb_we    <= 1'b0;
            fb_addr  <= '0;
            fb_wdata <= '0;
            done     <= 1'b0;
        end else begin
            done <= (state == DRAIN) && !v1;
            v1   <= issue;
            r1   <= spr_addr[SPR_ADDR_WIDTH-1:CW];
            c1   <= spr_addr[CW-1:0];
            if (state == IDLE && start) begin
                x_l      <= x;
                y_l      <= y;
                spr_addr <= '0;
            end else if (issue && spr_addr != LAST_ADDR) begin
                spr_addr <= spr_addr + 1'b1;
            end
            fb_we <= v1 && on_screen && opaque;
            if (v1) begin
                fb_addr  <= FB_ADDR_WIDTH'({ty[YW-1:0], tx[XW-1:0]});
                fb_wdata <= spr_data;
            end
        end
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed self-checking bench for sprite_blitter with a synchronous-read sprite ROM model.
module tb_sprite_blitter;

    localparam int N = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  x = '0;
    logic [6:0]  y = '0;
    logic        busy, done, fb_we;
    logic [9:0]  spr_addr;
    logic [12:0] spr_data;
    logic [14:0] fb_addr;
    logic [12:0] fb_wdata;

    logic [12:0] rom [N];

    int checks = 0;
    int passes = 0;

    // Per-blit observations
    int nw, first_e, done_e, bad, wraps, busy_n, last_addr, w783, d783;

    sprite_blitter #(
        .DATA_WIDTH(13), .FB_ADDR_WIDTH(15), .FB_WIDTH(256), .FB_HEIGHT(128),
        .SPR_W(32), .SPR_H(32), .SPR_ADDR_WIDTH(10), .TRANSPARENT(13'h0000)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .x(x), .y(y),
        .busy(busy), .done(done), .spr_addr(spr_addr), .spr_data(spr_data),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) spr_data <= rom[spr_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic logic exp_we(input int k, input int bx, input int by);
        int tx, ty;
        tx = bx + k % 32;
        ty = by + k / 32;
`ifdef BLIT_TRANSPARENCY_EN
        return (tx < 256) && (ty < 128) && (rom[k] != 13'h0000);
`else
        return (tx < 256) && (ty < 128);
`endif
    endfunction

    // Runs one blit from E0; pulse_at re-asserts start with x=50, rst_at resets and stops early.
    task automatic blit(input int bx, input int by, input int pulse_at, input int rst_at);
        int k, ea;
        logic we_x;
        nw = 0; first_e = -1; done_e = -1; bad = 0; wraps = 0; busy_n = 0;
        last_addr = -1; w783 = 0; d783 = -1;
        x = 8'(bx); y = 7'(by); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (busy !== 1'b1 || spr_addr !== 10'd0 || done !== 1'b0) bad++;
        if (busy) busy_n++;
        for (int e = 1; e <= 1100; e++) begin
            start = (e == pulse_at);
            if (e == pulse_at) x = 8'd50;
            rst = (e == rst_at);
            @(posedge clk); #1;
            start = 1'b0;
            rst = 1'b0;
            if (e == rst_at) break;
            k = e - 2;
            we_x = (k >= 0 && k < N) ? exp_we(k, bx, by) : 1'b0;
            if (fb_we !== we_x) bad++;
            if (fb_we && we_x) begin
                ea = (by + k / 32) * 256 + bx + k % 32;
                if (fb_addr !== 15'(ea) || fb_wdata !== rom[k]) bad++;
            end
            if (fb_we) begin
                nw++;
                if (first_e < 0) first_e = e;
                last_addr = int'(fb_addr);
                if (int'(fb_addr[7:0]) < bx || int'(fb_addr[14:8]) < by) wraps++;
                if (fb_addr == 15'd783) begin w783 = 1; d783 = int'(fb_wdata); end
            end
            if (e < N && spr_addr !== 10'(e)) bad++;
            if (busy) busy_n++;
            if (done) begin done_e = e; break; end
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) rom[i] = 13'h1FFF;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_fb_we", 32'(fb_we), 0);
        check("rst_fb_addr", 32'(fb_addr), 0);
        check("rst_fb_wdata", 32'(fb_wdata), 0);
        check("rst_spr_addr", 32'(spr_addr), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Opaque sprite at origin
        blit(0, 0, -1, -1);
        check("opq_writes", 32'(nw), 1024);
        check("opq_first_edge", 32'(first_e), 2);
        check("opq_last_addr", 32'(last_addr), 7967);
        check("opq_done_edge", 32'(done_e), 1026);
        check("opq_busy_cycles", 32'(busy_n), 1026);
        check("opq_seq_errors", 32'(bad), 0);

        // Back-to-back: start sampled on the edge right after done
        blit(0, 0, -1, -1);
        check("b2b_first_edge", 32'(first_e), 2);
        check("b2b_done_edge", 32'(done_e), 1026);
        check("b2b_seq_errors", 32'(bad), 0);

        // Colour-keyed pixel 5 at (10,3) lands on address 783
        rom[5] = 13'h0000;
        blit(10, 3, -1, -1);
`ifdef BLIT_TRANSPARENCY_EN
        check("key_writes", 32'(nw), 1023);
        check("key_783_written", 32'(w783), 0);
`else
        check("key_writes", 32'(nw), 1024);
        check("key_783_written", 32'(w783), 1);
        check("key_783_data", 32'(d783), 0);
`endif
        check("key_seq_errors", 32'(bad), 0);
        rom[5] = 13'h1FFF;

        // Clipping at the bottom-right corner
        blit(240, 112, -1, -1);
        check("clip_writes", 32'(nw), 256);
        check("clip_wraps", 32'(wraps), 0);
        check("clip_done_edge", 32'(done_e), 1026);
        check("clip_seq_errors", 32'(bad), 0);

        // Start pulse while busy is ignored
        blit(0, 0, 500, -1);
        check("restart_writes", 32'(nw), 1024);
        check("restart_done_edge", 32'(done_e), 1026);
        check("restart_seq_errors", 32'(bad), 0);

        // Reset mid-blit, then a clean blit starting two edges later
        @(posedge clk); #1;
        blit(0, 0, -1, 300);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_fb_we", 32'(fb_we), 0);
        check("midrst_spr_addr", 32'(spr_addr), 0);
        check("midrst_done_seen", 32'(done_e), 32'hFFFF_FFFF);
        @(posedge clk); #1;
        check("midrst_idle_done", 32'(done), 0);
        check("midrst_idle_we", 32'(fb_we), 0);
        blit(0, 0, -1, -1);
        check("postrst_writes", 32'(nw), 1024);
        check("postrst_first_edge", 32'(first_e), 2);
        check("postrst_done_edge", 32'(done_e), 1026);
        check("postrst_seq_errors", 32'(bad), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
